// File: rtl/bolme_pkg.sv
// Shared types and constants for the divider initiator (bolme_denetleyici).
package bolme_pkg;

  typedef enum logic [1:0] {
    ISLEM_DIV  = 2'b00,
    ISLEM_DIVU = 2'b01,
    ISLEM_REM  = 2'b10,
    ISLEM_REMU = 2'b11
  } islem_t;

  typedef enum logic [2:0] {
    DRENAJ,
    BOS,
    BASLAT,
    BEKLE,
    SONUC
  } durum_t;

  localparam int          DRENAJ_SURESI_VARSAYILAN = 19;
  localparam logic [31:0] EN_KUCUK_ISARETLI        = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        isaretli;
    logic        kalan_sec;
  } istek_t;

  function automatic logic tasma(input logic isaretli, input logic [31:0] a, input logic [31:0] b);
    return isaretli && (a == EN_KUCUK_ISARETLI) && (b == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/bolme_onbellegi.sv
// One-entry result cache: remembers the last divider result keyed on {a, b, signedness}.
module bolme_onbellegi
  import bolme_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        yaz,
  input  logic [31:0] yaz_a,
  input  logic [31:0] yaz_b,
  input  logic        yaz_isaretli,
  input  logic [31:0] yaz_bolum,
  input  logic [31:0] yaz_kalan,
  input  logic [31:0] sor_a,
  input  logic [31:0] sor_b,
  input  logic        sor_isaretli,
  output logic        isabet,
  output logic [31:0] bolum,
  output logic [31:0] kalan
);

  logic        gecerli;
  logic [31:0] a_q, b_q;
  logic        isaretli_q;

  always_ff @(posedge clk) begin
    if (rst) gecerli <= 1'b0;
    else if (yaz) gecerli <= 1'b1;
  end

  // Payload needs no reset: it is only observed through gecerli.
  always_ff @(posedge clk) begin
    if (yaz) begin
      a_q        <= yaz_a;
      b_q        <= yaz_b;
      isaretli_q <= yaz_isaretli;
      bolum      <= yaz_bolum;
      kalan      <= yaz_kalan;
    end
  end

  assign isabet = gecerli && (a_q == sor_a) && (b_q == sor_b) && (isaretli_q == sor_isaretli);

endmodule

// File: rtl/bolme_denetleyici.sv
// RV32M divide initiator for iki_bit_adimli_bolucu: decode, flags, start pulse, result hold.
// Optional one-entry result cache enabled by defining BOLME_ONBELLEK_EN.
module bolme_denetleyici
  import bolme_pkg::*;
#(
  parameter int DRENAJ_SURESI = DRENAJ_SURESI_VARSAYILAN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        istek_gecerli,
  output logic        istek_hazir,
  input  logic [1:0]  islem,
  input  logic [31:0] kaynak1,
  input  logic [31:0] kaynak2,
  output logic [31:0] sonuc,
  output logic        sonuc_gecerli,
  input  logic        sonuc_hazir,
  output logic [31:0] bolucu_a,
  output logic [31:0] bolucu_b,
  output logic        bolucu_istek,
  output logic        bolucu_isaretli,
  output logic        bolucu_overflow,
  output logic        bolucu_divbyzero,
  input  logic [31:0] bolucu_bolum,
  input  logic [31:0] bolucu_kalan,
  input  logic        bolucu_bitti
);

  localparam int SAYAC_W = $clog2(DRENAJ_SURESI + 2);

  durum_t             durum, durum_sonraki;
  logic [SAYAC_W-1:0] sayac;
  istek_t             ist;
  logic               ovf_q, dbz_q;
  logic [31:0]        sonuc_q;

  islem_t      op;
  logic        op_isaretli;
  logic        isabet;
  logic [31:0] ob_bolum, ob_kalan;
  logic        bitti_al;

  assign op          = islem_t'(islem);
  assign op_isaretli = (op == ISLEM_DIV) || (op == ISLEM_REM);
  assign bitti_al    = (durum == BEKLE) && bolucu_bitti;

`ifdef BOLME_ONBELLEK_EN
  bolme_onbellegi u_onbellek (
    .clk          (clk),
    .rst          (rst),
    .yaz          (bitti_al),
    .yaz_a        (ist.a),
    .yaz_b        (ist.b),
    .yaz_isaretli (ist.isaretli),
    .yaz_bolum    (bolucu_bolum),
    .yaz_kalan    (bolucu_kalan),
    .sor_a        (kaynak1),
    .sor_b        (kaynak2),
    .sor_isaretli (op_isaretli),
    .isabet       (isabet),
    .bolum        (ob_bolum),
    .kalan        (ob_kalan)
  );
`else
  assign isabet   = 1'b0;
  assign ob_bolum = '0;
  assign ob_kalan = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) durum <= DRENAJ;
    else     durum <= durum_sonraki;
  end

  always_comb begin
    durum_sonraki = durum;
    unique case (durum)
      DRENAJ: if (sayac == '0) durum_sonraki = BOS;
      BOS:    if (istek_gecerli) durum_sonraki = isabet ? SONUC : BASLAT;
      BASLAT: durum_sonraki = BEKLE;
      BEKLE:  if (bolucu_bitti) durum_sonraki = SONUC;
      SONUC:  if (sonuc_hazir) durum_sonraki = BOS;
      default: durum_sonraki = DRENAJ;
    endcase
  end

  always_comb begin
    istek_hazir   = 1'b0;
    bolucu_istek  = 1'b0;
    sonuc_gecerli = 1'b0;
    unique case (durum)
      BOS:     istek_hazir   = 1'b1;
      BASLAT:  bolucu_istek  = 1'b1;
      SONUC:   sonuc_gecerli = 1'b1;
      default: ;
    endcase
  end

  // Operands and flags are captured once at accept and stay put until the next
  // accept, so the divider sees stable inputs through its final re-read.
  always_ff @(posedge clk) begin
    if (rst) begin
      sayac   <= SAYAC_W'(DRENAJ_SURESI);
      ist     <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      sonuc_q <= '0;
    end else begin
      if (durum == DRENAJ && sayac != '0) sayac <= sayac - 1'b1;
      if (durum == BOS && istek_gecerli) begin
        ist   <= '{a: kaynak1, b: kaynak2, isaretli: op_isaretli, kalan_sec: islem[1]};
        ovf_q <= tasma(op_isaretli, kaynak1, kaynak2);
        dbz_q <= (kaynak2 == '0);
        if (isabet) sonuc_q <= islem[1] ? ob_kalan : ob_bolum;
      end
      if (bitti_al) sonuc_q <= ist.kalan_sec ? bolucu_kalan : bolucu_bolum;
    end
  end

  assign sonuc            = sonuc_q;
  assign bolucu_a         = ist.a;
  assign bolucu_b         = ist.b;
  assign bolucu_isaretli  = ist.isaretli;
  assign bolucu_overflow  = ovf_q;
  assign bolucu_divbyzero = dbz_q;

endmodule

// File: tb/tb_bolme_denetleyici.sv
// Scoreboard bench for bolme_denetleyici with a behavioural 18-cycle divider model.
module tb_bolme_denetleyici;

`ifdef BOLME_ONBELLEK_EN
  localparam bit ONBELLEK = 1'b1;
`else
  localparam bit ONBELLEK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        istek_gecerli = 1'b0;
  logic        istek_hazir;
  logic [1:0]  islem = 2'b00;
  logic [31:0] kaynak1 = '0, kaynak2 = '0;
  logic [31:0] sonuc;
  logic        sonuc_gecerli;
  logic        sonuc_hazir = 1'b1;
  logic [31:0] bolucu_a, bolucu_b;
  logic        bolucu_istek, bolucu_isaretli, bolucu_overflow, bolucu_divbyzero;
  logic [31:0] bolucu_bolum = '0, bolucu_kalan = '0;
  logic        bolucu_bitti = 1'b0;

  always #5 clk = ~clk;

  bolme_denetleyici dut (
    .clk(clk), .rst(rst),
    .istek_gecerli(istek_gecerli), .istek_hazir(istek_hazir),
    .islem(islem), .kaynak1(kaynak1), .kaynak2(kaynak2),
    .sonuc(sonuc), .sonuc_gecerli(sonuc_gecerli), .sonuc_hazir(sonuc_hazir),
    .bolucu_a(bolucu_a), .bolucu_b(bolucu_b), .bolucu_istek(bolucu_istek),
    .bolucu_isaretli(bolucu_isaretli), .bolucu_overflow(bolucu_overflow),
    .bolucu_divbyzero(bolucu_divbyzero),
    .bolucu_bolum(bolucu_bolum), .bolucu_kalan(bolucu_kalan), .bolucu_bitti(bolucu_bitti)
  );

  // Divider model: no reset, start on istek, bitti 18 cycles after the istek cycle,
  // results taken from the operand pins at the final step.
  logic [4:0] adim = '0;
  always @(posedge clk) begin
    if (bolucu_istek) begin
      adim         <= 5'd17;
      bolucu_bitti <= 1'b0;
    end else if (adim != 0) begin
      adim         <= adim - 1'b1;
      bolucu_bitti <= (adim == 5'd1);
      if (adim == 5'd1) begin
        if (bolucu_divbyzero) begin
          bolucu_bolum <= 32'hFFFF_FFFF;
          bolucu_kalan <= bolucu_a;
        end else if (bolucu_overflow) begin
          bolucu_bolum <= bolucu_a;
          bolucu_kalan <= '0;
        end else if (bolucu_isaretli) begin
          bolucu_bolum <= $signed(bolucu_a) / $signed(bolucu_b);
          bolucu_kalan <= $signed(bolucu_a) % $signed(bolucu_b);
        end else begin
          bolucu_bolum <= bolucu_a / bolucu_b;
          bolucu_kalan <= bolucu_a % bolucu_b;
        end
      end
    end else begin
      bolucu_bitti <= 1'b0;
    end
  end

  typedef struct {
    logic [31:0] deger;
    int          gecikme;
    bit          isabet;
  } beklenen_t;

  beklenen_t beklenen_q[$];
  int        kabul_q[$];
  int        checks = 0, errors = 0;

  function automatic void kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] istenen);
    checks++;
    if (gercek !== istenen) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", ad, gercek, istenen, $time);
    end
  endfunction

  // Monitor: records accept cycles, checks value, latency, divider use and hold.
  int          ncyc = 0;
  bit          sunuluyor = 0, hs_sonra = 0, istek_gor = 0;
  logic [31:0] tutulan = '0;
  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      kabul_q.delete();
      sunuluyor = 0;
      hs_sonra  = 0;
    end else begin
      if (bolucu_istek) istek_gor = 1;
      if (beklenen_q.size() == 0) begin
        kontrol("beklenmeyen_sonuc", {31'b0, sonuc_gecerli}, 32'd0);
      end else if (sonuc_gecerli) begin
        if (!sunuluyor) begin
          kontrol("sonuc", sonuc, beklenen_q[0].deger);
          if (kabul_q.size() == 0) kontrol("kabul_yok", 32'd0, 32'd1);
          else kontrol("gecikme", ncyc - kabul_q[0], beklenen_q[0].gecikme);
          kontrol("bolucu_istek_kullanimi", {31'b0, istek_gor}, {31'b0, !beklenen_q[0].isabet});
          tutulan = sonuc;
        end else begin
          kontrol("sonuc_kararli", sonuc, tutulan);
        end
        kontrol("hazir_sonuc_sirasinda", {31'b0, istek_hazir}, 32'd0);
        if (sonuc_hazir) begin
          void'(beklenen_q.pop_front());
          if (kabul_q.size() != 0) void'(kabul_q.pop_front());
        end
      end
      if (hs_sonra) kontrol("hazir_el_sikismadan_sonra", {31'b0, istek_hazir}, 32'd1);
      hs_sonra  = sonuc_gecerli && sonuc_hazir;
      sunuluyor = sonuc_gecerli && !sonuc_hazir;
      if (istek_gecerli && istek_hazir) begin
        kabul_q.push_back(ncyc);
        istek_gor = 0;
      end
    end
  end

  task automatic gonder(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] deger, input bit isabet, input bit bekle_sonuc);
    bit kabul = 0;
    @(posedge clk); #1;
    if (bekle_sonuc) beklenen_q.push_back('{deger: deger, gecikme: isabet ? 1 : 20, isabet: isabet});
    islem = op; kaynak1 = a; kaynak2 = b; istek_gecerli = 1'b1;
    for (int i = 0; i < 200 && !kabul; i++) begin
      @(negedge clk);
      if (istek_hazir) kabul = 1;
    end
    if (!kabul) kontrol("kabul_zaman_asimi", 32'd0, 32'd1);
    @(posedge clk); #1;
    istek_gecerli = 1'b0;
  endtask

  task automatic bosalt();
    int n = 0;
    while (beklenen_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    kontrol("bosaltma_zaman_asimi", beklenen_q.size(), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    kontrol("reset_istek_hazir", {31'b0, istek_hazir}, 32'd0);
    kontrol("reset_sonuc_gecerli", {31'b0, sonuc_gecerli}, 32'd0);
    kontrol("reset_sonuc", sonuc, 32'd0);
    kontrol("reset_bolucu_ab", bolucu_a | bolucu_b, 32'd0);
    kontrol("reset_bolucu_bayrak",
            {28'b0, bolucu_istek, bolucu_isaretli, bolucu_overflow, bolucu_divbyzero}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    gonder(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 1);
    gonder(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, ONBELLEK, 1);
    gonder(2'b01, 32'd100, 32'd7, 32'd14, 0, 1);
    gonder(2'b11, 32'd100, 32'd7, 32'd2, ONBELLEK, 1);
    gonder(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1);
    gonder(2'b10, 32'd5, 32'd0, 32'd5, 0, 1);
    gonder(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1);
    gonder(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, ONBELLEK, 1);
    bosalt();

    // Backpressure: hold sonuc_hazir low for 5 cycles of a valid result.
    sonuc_hazir = 1'b0;
    gonder(2'b01, 32'd1000, 32'd10, 32'd100, 0, 1);
    begin
      int n = 0;
      while (!sonuc_gecerli && n < 100) begin @(negedge clk); n++; end
      kontrol("geri_basinc_sonuc_gecerli", {31'b0, sonuc_gecerli}, 32'd1);
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #1 sonuc_hazir = 1'b1;
    bosalt();

    // Abort in cycle 8 of a division; the stray bitti must stay invisible.
    gonder(2'b01, 32'd77, 32'd5, 32'd0, 0, 0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    begin
      int hazir_gorulen = 0;
      for (int i = 0; i < 19; i++) begin
        @(negedge clk);
        if (istek_hazir) hazir_gorulen++;
      end
      kontrol("drenaj_hazir_sifir", hazir_gorulen, 32'd0);
    end
    gonder(2'b01, 32'd9, 32'd3, 32'd3, 0, 1);
    bosalt();

    if (ONBELLEK) begin
      gonder(2'b00, 32'd100, 32'd7, 32'd14, 0, 1);
      gonder(2'b10, 32'd100, 32'd7, 32'd2, 1, 1);
      gonder(2'b01, 32'd100, 32'd7, 32'd14, 0, 1);
    end else begin
      gonder(2'b00, 32'd100, 32'd7, 32'd14, 0, 1);
      gonder(2'b10, 32'd100, 32'd7, 32'd2, 0, 1);
    end
    bosalt();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
